// File: rtl/tcam_hit_scanner_if.sv
// rtl/tcam_hit_scanner_if.sv - compare-result input and matched-address stream bundle for tcam_hit_scanner
interface tcam_hit_scanner_if #(
    parameter int Words       = 16,
    parameter int AddressSize = 4,
    parameter int ID_Width    = 4
);
    logic                   Valid_In;
    logic                   Ready_Out;
    logic [Words-1:0]       Hitline_In;
    logic [ID_Width-1:0]    PacketID_In;
    logic                   Valid_Out;
    logic                   Ready_In;
    logic [AddressSize-1:0] Addr_Out;
    logic [ID_Width-1:0]    PacketID_Out;
    logic                   Last_Out;
    logic                   Busy_Out;

    // master is the scanner side, slave is the TCAM/consumer environment
    modport master (
        input  Valid_In, Hitline_In, PacketID_In, Ready_In,
        output Ready_Out, Valid_Out, Addr_Out, PacketID_Out, Last_Out, Busy_Out
    );

    modport slave (
        output Valid_In, Hitline_In, PacketID_In, Ready_In,
        input  Ready_Out, Valid_Out, Addr_Out, PacketID_Out, Last_Out, Busy_Out
    );
endinterface

// File: rtl/tcam_hit_scanner.sv
// rtl/tcam_hit_scanner.sv - serialises TCAM hit lines into ascending address beats; MISS_CNT_EN adds a zero-hit counter
module tcam_hit_scanner #(
    parameter int Words       = 16,
    parameter int AddressSize = 4,
    parameter int ID_Width    = 4
`ifdef MISS_CNT_EN
    ,
    parameter int MISS_CNT_W  = 8
`endif
) (
    input  logic               clk,
    input  logic               rst,
    tcam_hit_scanner_if.master bus
`ifdef MISS_CNT_EN
    ,
    output logic [MISS_CNT_W-1:0] Miss_Count_Out
`endif
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [Words-1:0] ONE = Words'(1);

    state_t                 state_q, state_n;
    logic [Words-1:0]       pending_q, pending_n;
    logic [AddressSize-1:0] addr_q, addr_n;
    logic [ID_Width-1:0]    pid_q, pid_n;
    logic                   last_q, last_n;

    function automatic logic [AddressSize-1:0] lowest_index(input logic [Words-1:0] v);
        logic [AddressSize-1:0] idx;
        idx = '0;
        for (int i = Words - 1; i >= 0; i--) begin
            if (v[i]) idx = AddressSize'(i);
        end
        return idx;
    endfunction

    // v & (v - 1) drops the lowest set bit, matching the index just emitted
    always_comb begin
        state_n   = state_q;
        pending_n = pending_q;
        addr_n    = addr_q;
        pid_n     = pid_q;
        last_n    = last_q;
        case (state_q)
            IDLE: begin
                if (bus.Valid_In && (bus.Hitline_In != '0)) begin
                    addr_n    = lowest_index(bus.Hitline_In);
                    pid_n     = bus.PacketID_In;
                    pending_n = bus.Hitline_In & (bus.Hitline_In - ONE);
                    last_n    = (pending_n == '0);
                    state_n   = SCAN;
                end
            end
            SCAN: begin
                if (bus.Ready_In) begin
                    if (last_q) begin
                        last_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        addr_n    = lowest_index(pending_q);
                        pending_n = pending_q & (pending_q - ONE);
                        last_n    = (pending_n == '0);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            addr_q    <= '0;
            pid_q     <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            pending_q <= pending_n;
            addr_q    <= addr_n;
            pid_q     <= pid_n;
            last_q    <= last_n;
        end
    end

    assign bus.Ready_Out    = (state_q == IDLE);
    assign bus.Valid_Out    = (state_q == SCAN);
    assign bus.Busy_Out     = (state_q == SCAN);
    assign bus.Addr_Out     = addr_q;
    assign bus.PacketID_Out = pid_q;
    assign bus.Last_Out     = last_q;

`ifdef MISS_CNT_EN
    logic [MISS_CNT_W-1:0] miss_q, miss_n;

    // saturates rather than wrapping so a flood of misses never reads as few
    always_comb begin
        miss_n = miss_q;
        if ((state_q == IDLE) && bus.Valid_In && (bus.Hitline_In == '0) && (miss_q != '1))
            miss_n = miss_q + MISS_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) miss_q <= '0;
        else     miss_q <= miss_n;
    end

    assign Miss_Count_Out = miss_q;
`endif

endmodule

// File: doc/tcam_hit_scanner.md
Name: tcam_hit_scanner

Overview:
- Sits directly downstream of the TCAM memory's compare path.
- Accepts one compare result per packet: a Words-wide hit-line vector plus the PacketID that produced it.
- Serialises every set hit line into a stream of matched addresses, lowest index first, over a valid/ready handshake.
- The consumer (synapse/weight readout) receives one address per beat, with a last-beat marker.

Parameters:
Words, 16, number of TCAM words = hit-line vector width
AddressSize, 4, address width; must satisfy 2**AddressSize >= Words
ID_Width, 4, PacketID width
MISS_CNT_W, 8, miss counter width (used only with optional feature)

Ports:
clk  input  1  clock; all logic rising-edge
rst  input  1  synchronous reset, active-high
Valid_In  input  1  compare result valid
Ready_Out  output  1  scanner can accept a compare result
Hitline_In  input  Words  hit-line vector; bit i = TCAM word i matched
PacketID_In  input  ID_Width  packet ID that produced the compare
Valid_Out  output  1  Addr_Out/PacketID_Out/Last_Out valid
Ready_In  input  1  consumer accepts the current beat
Addr_Out  output  AddressSize  matched word address
PacketID_Out  output  ID_Width  ID of the packet being serialised
Last_Out  output  1  current beat is the final hit of this packet
Busy_Out  output  1  scan in progress (state SCAN)
Miss_Count_Out  output  MISS_CNT_W  zero-hit packet count; present only with MISS_CNT_EN

Behaviour:
- Reset (rst=1 at a clk edge) applies regardless of state, including mid-scan; any in-flight packet is discarded.
  - Outputs after reset: Valid_Out=0, Addr_Out=0, PacketID_Out=0, Last_Out=0, Busy_Out=0, Ready_Out=1, Miss_Count_Out=0.
  - Internal pending vector cleared; state=IDLE.
- States: IDLE, SCAN.
- Ready_Out = (state==IDLE); combinational from state only. Valid_In is ignored while Ready_Out=0.
- IDLE, accept (Valid_In & Ready_Out):
  - Hitline_In==0: packet dropped, no beat emitted, state stays IDLE, Ready_Out stays 1 (back-to-back accepts allowed); miss counter increments if enabled.
  - Hitline_In!=0: next edge registers Addr_Out=index of lowest set bit, PacketID_Out=PacketID_In, pending=Hitline_In with that bit cleared, Last_Out=(pending==0), Valid_Out=1, Busy_Out=1, state=SCAN.
  - Latency: first beat valid the cycle after accept.
- SCAN:
  - While Ready_In=0, all outputs hold stable; Valid_Out never drops without a handshake.
  - On handshake (Valid_Out & Ready_In) with pending!=0: next edge loads the next lowest set index into Addr_Out, clears that bit in pending, updates Last_Out. One beat per cycle; no bubbles.
  - On handshake with Last_Out=1: next edge sets Valid_Out=0, Last_Out=0, Busy_Out=0, state=IDLE. Addr_Out/PacketID_Out hold their last values.
- Throughput: N hits take N beats, plus 1 idle cycle before the next accept (Ready_Out rises the cycle after the last handshake).
- Addresses are emitted strictly ascending and each exactly once. Hitline_In bits at index >= Words do not exist; Addr_Out upper bits are zero when 2**AddressSize > Words.
- All-ones hit line: Words beats, addresses 0..Words-1, Last_Out only on address Words-1.

Optional Feature:
Macro MISS_CNT_EN.
- Defined: Miss_Count_Out port exists.
  - Increments by 1 on each accepted zero-hit packet.
  - Saturates at all-ones; no wrap.
  - Cleared only by rst.
- Undefined: no port, no counter logic; zero-hit packets are silently dropped.

Test Plan:
- Reset mid-scan: accept Hitline=16'hFFFF, ID=3, assert rst after 2 beats -> next cycle Valid_Out=0, Ready_Out=1, Busy_Out=0; a subsequent Hitline=16'h0001 yields a single beat Addr=0, Last=1.
- Multi-hit, Ready_In=1: Hitline=16'h8421, ID=5 -> beats on 4 consecutive cycles Addr=0,5,10,15, PacketID_Out=5 throughout, Last_Out=1 only on Addr=15; Ready_Out=1 the cycle after.
- Backpressure: Hitline=16'h0006, ID=9, Ready_In held 0 for 3 cycles -> Addr_Out=1 stable with Valid_Out=1; release -> Addr=1, then Addr=2 with Last=1.
- Valid_In during SCAN: present Hitline=16'h0010 while busy -> ignored; only the first packet's beats appear.
- Zero hit: Valid_In with Hitline=0 on 3 consecutive cycles -> no Valid_Out, Ready_Out stays 1; with MISS_CNT_EN, Miss_Count_Out=3.
- Saturation (MISS_CNT_EN, MISS_CNT_W=2): 5 zero-hit packets -> Miss_Count_Out=3.
